// File: rtl/cast_noc_pkg.sv
// Shared types for the cast NoC router: flit and one-hot VC vectors.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cast_noc_pkg;

   localparam int CAST_VN = 4;
   localparam int CAST_DW = 32;

   typedef logic [CAST_DW-1:0] flit_t;
   typedef logic [CAST_VN-1:0] vc_oh_t;

   localparam vc_oh_t VC_NONE = '0;

   // Index of the set bit of a one-hot VC vector (0 when none is set).
   function automatic int unsigned vc_idx(input vc_oh_t oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < CAST_VN; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/cast_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, one-hot grant.
// Latency: grant is combinational from req; pointer updates on the next edge.
// Backpressure: pointer holds unless en & |req, so a stalled consumer keeps priority fixed.
module cast_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_nxt;

   // Circular scan from the pointer; remember the slot after the winner.
   always_comb begin
      logic          found;
      int            s;
      logic [PW-1:0] idx;
      gnt     = '0;
      ptr_nxt = ptr_q;
      found   = 1'b0;
      s       = 0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         s = int'(ptr_q) + i;
         if (s >= N) s = s - N;
         idx = PW'(s);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_nxt  = (s == N - 1) ? '0 : PW'(s + 1);
         end
      end
   end

   // Pointer advances only when a grant is actually consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en && (|req)) begin
         ptr_q <= ptr_nxt;
      end
   end

endmodule

// File: rtl/cast_output_port_stage.sv
// Link transmit stage: round-robin picks one VC flit per cycle into an output register.
// Latency: 1 cycle from ready_o[v] to the flit on data_o/vc_o/valid_o.
// Backpressure: ready_i low holds the register frozen and drops all ready_o; optional perf counters via CAST_OUT_PERF_CNT_EN.
module cast_output_port_stage
   import cast_noc_pkg::*;
#(
   parameter int VN = CAST_VN,
   parameter int DW = CAST_DW
`ifdef CAST_OUT_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VN-1:0][DW-1:0] data_i,
   input  logic [VN-1:0]        valid_i,
   output logic [VN-1:0]        ready_o,
   output logic [DW-1:0]        data_o,
   output logic                 valid_o,
   output logic [VN-1:0]        vc_o,
   input  logic                 ready_i
`ifdef CAST_OUT_PERF_CNT_EN
   ,
   output logic [VN-1:0][CNT_W-1:0] tx_cnt,
   output logic [CNT_W-1:0]         stall_cnt
`endif
);

   logic [DW-1:0] data_q;
   logic [VN-1:0] vc_q;
   logic          valid_q;

   logic          send;
   logic          load_en;
   logic [VN-1:0] gnt;
   logic [DW-1:0] flit_sel;

   assign send    = valid_q & ready_i;
   assign load_en = ~valid_q | ready_i;

   cast_rr_arbiter #(.N(VN)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (valid_i),
      .en  (load_en),
      .gnt (gnt)
   );

   assign ready_o = gnt & {VN{load_en & ~rst}};

   // One-hot mux of the granted VC's flit.
   always_comb begin
      flit_sel = '0;
      for (int v = 0; v < VN; v++) begin
         if (gnt[v]) flit_sel = data_i[v];
      end
   end

   // Output register: load on grant, otherwise clear valid once the flit is sent.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         vc_q    <= VN'(VC_NONE);
         valid_q <= 1'b0;
      end else if (load_en && (|gnt)) begin
         data_q  <= flit_sel;
         vc_q    <= gnt;
         valid_q <= 1'b1;
      end else if (send) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign vc_o    = vc_q;
   assign valid_o = valid_q;

`ifdef CAST_OUT_PERF_CNT_EN
   logic [VN-1:0][CNT_W-1:0] tx_cnt_q;
   logic [CNT_W-1:0]         stall_cnt_q;

   // Per-VC sent flits and stalled cycles, wrapping at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int v = 0; v < VN; v++) begin
            if (send && vc_q[v]) tx_cnt_q[v] <= tx_cnt_q[v] + CNT_W'(1);
         end
         if (valid_q && !ready_i) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign tx_cnt    = tx_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cast_output_port_stage.sv
// Scoreboard bench: queued upstream sources, transaction-level link model, negedge monitor.
// Latency: checks ready_o the cycle of accept and the link flit one cycle later.
// Backpressure: drives ready_i directed and random; a stalled flit must stay at the scoreboard head.
module tb_cast_output_port_stage;

   localparam int VN = 4;
   localparam int DW = 32;
`ifdef CAST_OUT_PERF_CNT_EN
   localparam int CNT_W = 4;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [VN-1:0][DW-1:0] data_i;
   logic [VN-1:0]        valid_i;
   logic [VN-1:0]        ready_o;
   logic [DW-1:0]        data_o;
   logic                 valid_o;
   logic [VN-1:0]        vc_o;
   logic                 ready_i;
`ifdef CAST_OUT_PERF_CNT_EN
   logic [VN-1:0][CNT_W-1:0] tx_cnt;
   logic [CNT_W-1:0]         stall_cnt;
`endif

   always #5 clk = ~clk;

   cast_output_port_stage #(
      .VN(VN),
      .DW(DW)
`ifdef CAST_OUT_PERF_CNT_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .vc_o      (vc_o),
      .ready_i   (ready_i)
`ifdef CAST_OUT_PERF_CNT_EN
      ,
      .tx_cnt    (tx_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   typedef struct {
      int          vc;
      logic [31:0] dat;
   } flit_rec_t;

   logic [31:0] src [VN][$];     // upstream flits waiting per VC
   flit_rec_t   exp_q [$];       // flit expected on the link (head = currently held)
   int          sent_vc [$];
   logic [31:0] sent_dat [$];
   int          sent_cyc [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit m_held = 1'b0;
   int m_ptr = 0;
   int m_tx [VN];
   int m_stall = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      m_held  = 1'b0;
      m_ptr   = 0;
      m_stall = 0;
      exp_q.delete();
      for (int v = 0; v < VN; v++) m_tx[v] = 0;
   endtask

   // One clock: present sources, predict the grant, step the model at the edge.
   task automatic cycle();
      int            w;
      int            c;
      logic [VN-1:0] exp_rdy;
      logic          rdy_s;
      logic          rst_s;
      for (int v = 0; v < VN; v++) begin
         valid_i[v] = (src[v].size() > 0);
         data_i[v]  = (src[v].size() > 0) ? src[v][0] : 32'h0;
      end
      #1;
      w = -1;
      if (!rst && (!m_held || ready_i)) begin
         for (int i = 0; i < VN; i++) begin
            c = (m_ptr + i) % VN;
            if (w < 0 && src[c].size() > 0) w = c;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("ready_o", ready_o, exp_rdy);
      rdy_s = ready_i;
      rst_s = rst;
      @(posedge clk);
      if (rst_s) begin
         clear_model();
      end else if (w >= 0) begin
         flit_rec_t r;
         r.vc  = w;
         r.dat = src[w].pop_front();
         exp_q.push_back(r);
         m_held = 1'b1;
         m_ptr  = (w + 1) % VN;
      end else if (rdy_s) begin
         m_held = 1'b0;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      sent_vc.delete();
      sent_dat.delete();
      sent_cyc.delete();
   endtask

   // Monitor: compare the link against the scoreboard head, retire on send.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("valid_o", valid_o, m_held);
            if (m_held && exp_q.size() > 0) begin
               logic [VN-1:0] oh;
               oh = '0;
               oh[exp_q[0].vc] = 1'b1;
               chk("data_o", data_o, exp_q[0].dat);
               chk("vc_o", vc_o, oh);
               if (!rst && ready_i) begin
                  sent_vc.push_back(exp_q[0].vc);
                  sent_dat.push_back(exp_q[0].dat);
                  sent_cyc.push_back(cyc);
                  m_tx[exp_q[0].vc]++;
                  void'(exp_q.pop_front());
               end else if (!rst) begin
                  m_stall++;
               end
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      ready_i = 1'b0;
      valid_i = '0;
      data_i  = '0;
      clear_model();
      @(posedge clk);
      #1;
      do_reset();
      mon_en = 1'b1;
      chk("reset valid_o", valid_o, 1'b0);
      chk("reset data_o", data_o, 32'h0);
      chk("reset vc_o", vc_o, 4'b0000);
`ifdef CAST_OUT_PERF_CNT_EN
      chk("reset stall_cnt", stall_cnt, 0);
      chk("reset tx_cnt0", tx_cnt[0], 0);
`endif

      // Single flit on VC2.
      ready_i = 1'b1;
      src[2].push_back(32'hA5A5_0002);
      run(3);
      chk("single count", sent_vc.size(), 1);

      // All VCs valid: strict rotation with no bubbles.
      do_reset();
      ready_i = 1'b1;
      for (int k = 0; k < 2; k++)
         for (int v = 0; v < VN; v++) src[v].push_back(32'h100 + v * 16 + k);
      run(10);
      chk("rr count", sent_vc.size(), 8);
      for (int k = 0; k < 8 && k < sent_vc.size(); k++) begin
         chk("rr order", sent_vc[k], k % VN);
         if (k > 0) chk("rr no bubble", sent_cyc[k] - sent_cyc[k-1], 1);
      end

      // Stall: VC1 flit held for 5 cycles, then a VC0 flit follows at once.
      do_reset();
      ready_i = 1'b1;
      src[1].push_back(32'h11);
      cycle();
      ready_i = 1'b0;
      src[0].push_back(32'h22);
      run(5);
      chk("stall data_o", data_o, 32'h11);
      chk("stall vc_o", vc_o, 4'b0010);
      ready_i = 1'b1;
      run(3);
      chk("stall sends", sent_dat.size(), 2);
      if (sent_dat.size() == 2) begin
         chk("stall second", sent_dat[1], 32'h22);
         chk("stall gap", sent_cyc[1] - sent_cyc[0], 1);
      end

      // Reset while a flit is stalled on the link.
      do_reset();
      ready_i = 1'b1;
      src[2].push_back(32'h44);
      cycle();
      ready_i = 1'b0;
      run(2);
      do_reset();
      chk("rst mid valid_o", valid_o, 1'b0);
      chk("rst mid vc_o", vc_o, 4'b0000);
      ready_i = 1'b1;
      for (int v = 0; v < VN; v++) src[v].push_back(32'h200 + v);
      run(6);
      chk("rst mid count", sent_vc.size(), 4);
      if (sent_vc.size() > 0) chk("rst mid first vc", sent_vc[0], 0);

      // VC3 back-to-back then drain.
      do_reset();
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) src[3].push_back(32'h30 + k);
      run(5);
      chk("b2b count", sent_dat.size(), 3);
      for (int k = 0; k < 3 && k < sent_dat.size(); k++) begin
         chk("b2b data", sent_dat[k], 32'h30 + k);
         if (k > 0) chk("b2b gap", sent_cyc[k] - sent_cyc[k-1], 1);
      end
      chk("b2b drained", valid_o, 1'b0);

`ifdef CAST_OUT_PERF_CNT_EN
      // 17 VC0 sends wrap the 4-bit counter; 3 stall cycles.
      do_reset();
      ready_i = 1'b1;
      for (int k = 0; k < 17; k++) src[0].push_back(32'h500 + k);
      run(18);
      src[0].push_back(32'h5FF);
      cycle();
      ready_i = 1'b0;
      run(3);
      chk("tx_cnt0 wrap", tx_cnt[0], 1);
      chk("stall_cnt", stall_cnt, 3);
      ready_i = 1'b1;
      run(2);
`endif

      // Randomized traffic with random backpressure and rare resets.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int v = 0; v < VN; v++)
            if ($urandom_range(0, 3) == 0 && src[v].size() < 4) src[v].push_back($urandom);
         ready_i = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 149) == 0);
         cycle();
      end
      rst     = 1'b0;
      ready_i = 1'b1;
      run(24);
      chk("drain scoreboard", exp_q.size(), 0);
      for (int v = 0; v < VN; v++) chk("drain src", src[v].size(), 0);
`ifdef CAST_OUT_PERF_CNT_EN
      for (int v = 0; v < VN; v++) chk("rand tx_cnt", tx_cnt[v], m_tx[v] % (1 << CNT_W));
      chk("rand stall_cnt", stall_cnt, m_stall % (1 << CNT_W));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
